// File: rtl/seven_segment_display_arbiter.sv
// rtl/seven_segment_display_arbiter.sv - round-robin owner of a shared 4-digit seven-segment display
// Optional macro SEVEN_SEGMENT_SOURCE_TAG_EN puts the owner index in the top digit.
module seven_segment_display_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DWELL_CYCLES = 1000000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [16*NUM_REQ-1:0] data_in,
    output logic [NUM_REQ-1:0]    grant,
    output logic [15:0]           display_data,
    output logic                  display_blank,
    output logic                  switch_pulse
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int DW_W  = $clog2(DWELL_CYCLES);
    localparam int BL_W  = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL_CYCLES - 1);
    localparam logic [BL_W-1:0] BLANK_LAST = BL_W'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t             state, state_n;
    logic [IDX_W-1:0]   ptr, ptr_n;
    logic [NUM_REQ-1:0] grant_q, grant_n;
    logic [15:0]        data_q, data_n;
    logic               blank_q, blank_n;
    logic               pulse_q, pulse_n;
    logic [BL_W-1:0]    bcnt, bcnt_n;
    logic [DW_W-1:0]    dcnt, dcnt_n;

    logic [NUM_REQ-1:0] arb_mask;
    logic               win_valid;
    logic [IDX_W-1:0]   win_idx;
    int                 rr_idx;
    logic [15:0]        cur_val, win_val;
    logic               load;

    // The pointer always names the current (or most recent) owner.
    function automatic logic [15:0] show_value(input logic [IDX_W-1:0] idx,
                                               input logic [16*NUM_REQ-1:0] din);
        logic [15:0] d;
        d = din[16*idx +: 16];
`ifdef SEVEN_SEGMENT_SOURCE_TAG_EN
        return {4'(idx), d[11:0]};
`else
        return d;
`endif
    endfunction

    assign cur_val = show_value(ptr, data_in);
    assign win_val = show_value(win_idx, data_in);

    // In SHOW the owner is excluded so re-arbitration only ever picks a different source.
    always_comb begin
        arb_mask  = (state == SHOW) ? (req & ~grant_q) : req;
        win_valid = 1'b0;
        win_idx   = '0;
        rr_idx    = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            rr_idx = int'(ptr) + i;
            if (rr_idx >= NUM_REQ) rr_idx = rr_idx - NUM_REQ;
            if (!win_valid && arb_mask[rr_idx]) begin
                win_valid = 1'b1;
                win_idx   = IDX_W'(rr_idx);
            end
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        grant_n = grant_q;
        data_n  = data_q;
        blank_n = blank_q;
        pulse_n = 1'b0;
        bcnt_n  = bcnt;
        dcnt_n  = dcnt;
        load    = 1'b0;
        case (state)
            IDLE: begin
                grant_n = '0;
                data_n  = '0;
                blank_n = 1'b1;
                load    = win_valid;
            end
            BLANK: begin
                blank_n = 1'b1;
                data_n  = cur_val;
                bcnt_n  = bcnt + BL_W'(1);
                if (bcnt == BLANK_LAST) begin
                    state_n = SHOW;
                    dcnt_n  = '0;
                    blank_n = 1'b0;
                end
            end
            SHOW: begin
                blank_n = 1'b0;
                data_n  = cur_val;
                if (dcnt != DWELL_LAST) dcnt_n = dcnt + DW_W'(1);
                if (!req[ptr] || dcnt == DWELL_LAST) begin
                    if (win_valid) begin
                        load = 1'b1;
                    end else if (!req[ptr]) begin
                        state_n = IDLE;
                        grant_n = '0;
                        data_n  = '0;
                        blank_n = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        if (load) begin
            state_n = BLANK;
            ptr_n   = win_idx;
            grant_n = NUM_REQ'(1) << win_idx;
            data_n  = win_val;
            blank_n = 1'b1;
            pulse_n = 1'b1;
            bcnt_n  = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            ptr     <= IDX_W'(NUM_REQ - 1);
            grant_q <= '0;
            data_q  <= '0;
            blank_q <= 1'b1;
            pulse_q <= 1'b0;
            bcnt    <= '0;
            dcnt    <= '0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            grant_q <= grant_n;
            data_q  <= data_n;
            blank_q <= blank_n;
            pulse_q <= pulse_n;
            bcnt    <= bcnt_n;
            dcnt    <= dcnt_n;
        end
    end

    assign grant         = grant_q;
    assign display_data  = data_q;
    assign display_blank = blank_q;
    assign switch_pulse  = pulse_q;
endmodule

// File: tb/tb_seven_segment_display_arbiter.sv
// tb/tb_seven_segment_display_arbiter.sv - self-checking bench for seven_segment_display_arbiter
module tb_seven_segment_display_arbiter;
    localparam int NR    = 4;
    localparam int DWELL = 8;
    localparam int BLANK = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [NR-1:0] req = '0;
    logic [63:0]   data_in = '0;
    logic [NR-1:0] grant;
    logic [15:0]   display_data;
    logic          display_blank;
    logic          switch_pulse;

    int total = 0;
    int bad   = 0;

    seven_segment_display_arbiter #(
        .NUM_REQ(NR), .DWELL_CYCLES(DWELL), .BLANK_CYCLES(BLANK)
    ) dut (
        .clock(clock), .reset(reset), .req(req), .data_in(data_in),
        .grant(grant), .display_data(display_data),
        .display_blank(display_blank), .switch_pulse(switch_pulse)
    );

    always #5 clock = ~clock;

    // Reference model: mode 0 idle, 1 blanking, 2 showing.
    int          m_mode = 0, m_owner = NR - 1, m_bleft = 0, m_shown = 0;
    logic [3:0]  m_grant = '0;
    logic [15:0] m_data = '0;
    logic        m_blank = 1'b1, m_pulse = 1'b0;

    function automatic logic [15:0] fmt(input int idx, input logic [63:0] din);
        logic [15:0] d;
        d = din[16*idx +: 16];
`ifdef SEVEN_SEGMENT_SOURCE_TAG_EN
        return {4'(idx), d[11:0]};
`else
        return d;
`endif
    endfunction

    function automatic int pick(input logic [3:0] mask, input int from);
        for (int i = 1; i <= NR; i++)
            if (mask[(from + i) % NR]) return (from + i) % NR;
        return -1;
    endfunction

    task automatic m_start(input int w);
        m_mode = 1; m_owner = w; m_grant = 4'(1 << w); m_pulse = 1'b1;
        m_blank = 1'b1; m_bleft = BLANK; m_data = fmt(w, data_in);
    endtask

    task automatic m_idle();
        m_mode = 0; m_grant = '0; m_data = '0; m_blank = 1'b1;
    endtask

    task automatic model_step();
        int  w;
        logic done, own;
        m_pulse = 1'b0;
        if (reset) begin
            m_idle();
            m_owner = NR - 1;
        end else if (m_mode == 0) begin
            w = pick(req, m_owner);
            if (w >= 0) m_start(w);
        end else if (m_mode == 1) begin
            m_data  = fmt(m_owner, data_in);
            m_bleft = m_bleft - 1;
            if (m_bleft == 0) begin m_mode = 2; m_shown = 0; m_blank = 1'b0; end
        end else begin
            done = (m_shown >= DWELL - 1);
            own  = req[m_owner];
            w    = pick(req & ~(4'b1 << m_owner), m_owner);
            if ((!own || done) && w >= 0) m_start(w);
            else if (!own) m_idle();
            else begin
                m_data = fmt(m_owner, data_in);
                if (!done) m_shown = m_shown + 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; req = '0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        req = 4'b1011;
        tick(); tick();
        total++;
        if ({grant, display_data, display_blank, switch_pulse} !== {4'b0, 16'h0, 1'b1, 1'b0}) begin
            bad++; $display("FAIL reset_state got=%b/%h/%b/%b exp=0000/0000/1/0", grant, display_data, display_blank, switch_pulse);
        end
        reset = 1'b0; req = '0;
        tick();
        #2 req = 4'b0100;
        #2 req = 4'b0000;
        tick();
        total++;
        if (grant !== 4'b0) begin bad++; $display("FAIL short_pulse grant got=%b exp=0000", grant); end
    endtask

    task automatic test_single();
        data_in[15:0] = 16'h1234; req = 4'b0001;
        tick();
        total++;
        if ({grant, switch_pulse, display_blank} !== {4'b0001, 1'b1, 1'b1}) begin
            bad++; $display("FAIL single_grant got=%b/%b/%b exp=0001/1/1", grant, switch_pulse, display_blank);
        end
        tick();
        total++;
        if ({switch_pulse, display_blank} !== 2'b01) begin
            bad++; $display("FAIL single_blank2 got=%b/%b exp=0/1", switch_pulse, display_blank);
        end
        tick();
        total++;
        if ({display_blank, display_data} !== {1'b0, fmt(0, data_in)}) begin
            bad++; $display("FAIL single_show got=%b/%h exp=0/%h", display_blank, display_data, fmt(0, data_in));
        end
    endtask

    task automatic test_alternate();
        logic [3:0] seq[$];
        int run = 0;
        do_reset();
        req = 4'b0101;
        for (int c = 0; c < 70; c++) begin
            tick();
            total++;
            if ({grant, display_data, display_blank, switch_pulse} !== {m_grant, m_data, m_blank, m_pulse}) begin
                bad++; $display("FAIL alt_model cyc=%0d got=%b/%h/%b/%b exp=%b/%h/%b/%b", c, grant, display_data,
                                display_blank, switch_pulse, m_grant, m_data, m_blank, m_pulse);
            end
            if (switch_pulse) seq.push_back(grant);
            if (!display_blank) run++;
            else if (run > 0) begin
                total++;
                if (run < DWELL) begin bad++; $display("FAIL alt_dwell got=%0d exp>=%0d", run, DWELL); end
                run = 0;
            end
        end
        total++;
        if (seq.size() < 3) begin bad++; $display("FAIL alt_count got=%0d exp>=3", seq.size()); end
        else if (seq[0] !== 4'b0001 || seq[1] !== 4'b0100 || seq[2] !== 4'b0001) begin
            bad++; $display("FAIL alt_seq got=%b,%b,%b exp=0001,0100,0001", seq[0], seq[1], seq[2]);
        end
    endtask

    task automatic test_hold();
        int pulses = 0, ghost = 0;
        logic shown = 1'b0;
        do_reset();
        data_in[47:32] = 16'hBEEF; req = 4'b0100;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (switch_pulse) pulses++;
            if (!display_blank) shown = 1'b1;
            else if (shown) ghost++;
        end
        total++;
        if (pulses != 1 || ghost != 0 || grant !== 4'b0100) begin
            bad++; $display("FAIL hold got=pulses %0d blanks %0d grant %b exp=1/0/0100", pulses, ghost, grant);
        end
        total++;
        if (display_data !== fmt(2, data_in)) begin bad++; $display("FAIL hold_beef got=%h exp=%h", display_data, fmt(2, data_in)); end
        data_in[47:32] = 16'hCAFE;
        tick();
        total++;
        if (display_data !== fmt(2, data_in)) begin bad++; $display("FAIL hold_cafe got=%h exp=%h", display_data, fmt(2, data_in)); end
    endtask

    task automatic test_release();
        do_reset();
        req = 4'b0010;
        repeat (6) tick();
        req = 4'b1000;
        tick();
        total++;
        if ({grant, switch_pulse, display_blank} !== {4'b1000, 1'b1, 1'b1}) begin
            bad++; $display("FAIL release_next got=%b/%b/%b exp=1000/1/1", grant, switch_pulse, display_blank);
        end
        do_reset();
        req = 4'b0010;
        repeat (6) tick();
        req = 4'b0000;
        tick();
        total++;
        if ({grant, display_data, display_blank} !== {4'b0, 16'h0, 1'b1}) begin
            bad++; $display("FAIL release_idle got=%b/%h/%b exp=0000/0000/1", grant, display_data, display_blank);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b0001; data_in[15:0] = 16'h5A5A;
        repeat (8) tick();
        reset = 1'b1;
        tick();
        total++;
        if ({grant, display_data, display_blank, switch_pulse} !== {4'b0, 16'h0, 1'b1, 1'b0}) begin
            bad++; $display("FAIL reset_mid got=%b/%h/%b/%b exp=0000/0000/1/0", grant, display_data, display_blank, switch_pulse);
        end
        reset = 1'b0; req = 4'b1111;
        tick();
        total++;
        if (grant !== 4'b0001) begin bad++; $display("FAIL reset_first got=%b exp=0001", grant); end
    endtask

    task automatic test_tag();
        logic [15:0] exp_v;
`ifdef SEVEN_SEGMENT_SOURCE_TAG_EN
        exp_v = 16'h2BCD;
`else
        exp_v = 16'hABCD;
`endif
        do_reset();
        data_in[47:32] = 16'hABCD; req = 4'b0100;
        repeat (4) tick();
        total++;
        if (display_data !== exp_v) begin bad++; $display("FAIL tag got=%h exp=%h", display_data, exp_v); end
    endtask

    task automatic test_random();
        int hold = 0;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            data_in = {$urandom, $urandom};
            if (hold == 0) begin
                req  = 4'($urandom_range(0, 15));
                hold = $urandom_range(1, 14);
            end
            hold--;
            tick();
            total++;
            if ({grant, display_data, display_blank, switch_pulse} !== {m_grant, m_data, m_blank, m_pulse}) begin
                bad++; $display("FAIL random cyc=%0d got=%b/%h/%b/%b exp=%b/%h/%b/%b", c, grant, display_data,
                                display_blank, switch_pulse, m_grant, m_data, m_blank, m_pulse);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_hold();
        test_release();
        test_reset_mid();
        test_tag();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
